// File: rtl/node_memory_mp.sv
// node_memory_mp
//   Node store for the tree engine: DEPTH entries of NODE_W bits, one
//   field-masked write port and two independent registered read ports.
//   After reset or a soft clear, an init engine fills every entry with the
//   INIT_MODE value, one entry per clock, before `ready` rises.
//
// Ports
//   clk                    clock, all state changes on posedge
//   reset                  asynchronous active-low reset
//   clear                  soft re-initialise request
//   wr_en/wr_addr/wr_data  write strobe, address, data
//   wr_mask                per-field write enable (FIELD_W bits per field)
//   rd_x_en/rd_x_addr      read strobe and address, x = a|b
//   rd_x_data/rd_x_valid   registered read data, valid for one cycle
//   ready                  init complete, accesses honoured
//   wr_err                 sticky out-of-range write flag
module node_memory_mp #(
    parameter int unsigned NODE_W    = 12,
    parameter int unsigned DEPTH     = 32,
    parameter int unsigned ADDR_W    = 5,
    parameter int unsigned FIELD_W   = 4,
    parameter int unsigned INIT_MODE = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clear,
    input  logic                      wr_en,
    input  logic [ADDR_W-1:0]         wr_addr,
    input  logic [NODE_W-1:0]         wr_data,
    input  logic [NODE_W/FIELD_W-1:0] wr_mask,
    input  logic                      rd_a_en,
    input  logic [ADDR_W-1:0]         rd_a_addr,
    output logic [NODE_W-1:0]         rd_a_data,
    output logic                      rd_a_valid,
    input  logic                      rd_b_en,
    input  logic [ADDR_W-1:0]         rd_b_addr,
    output logic [NODE_W-1:0]         rd_b_data,
    output logic                      rd_b_valid,
    output logic                      ready,
    output logic                      wr_err
);

    localparam int unsigned       NF      = NODE_W / FIELD_W;
    localparam int unsigned       IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

    typedef enum logic {S_INIT, S_READY} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   init_addr_q, init_addr_d;
    logic                wr_err_q, wr_err_d;
    logic [NODE_W-1:0]   rd_a_data_q, rd_a_data_d, rd_b_data_q, rd_b_data_d;
    logic                rd_a_valid_q, rd_a_valid_d, rd_b_valid_q, rd_b_valid_d;

    logic [NODE_W-1:0]   mem_q [DEPTH];
    logic                mem_we;
    logic [IDX_W-1:0]    mem_widx;
    logic [NODE_W-1:0]   mem_wdata;

    logic [NODE_W-1:0]   init_addr_val;
    logic [NODE_W-1:0]   init_val;
    logic                accept;
    logic                wr_in_range, rd_a_in_range, rd_b_in_range;
    logic                user_we;
    logic [NODE_W-1:0]   wr_merged;

    // Zero-extend or truncate the fill address to the node width.
    if (NODE_W > ADDR_W) begin : g_ext
        assign init_addr_val = {{(NODE_W - ADDR_W){1'b0}}, init_addr_q};
    end else if (NODE_W == ADDR_W) begin : g_eq
        assign init_addr_val = init_addr_q;
    end else begin : g_trunc
        assign init_addr_val = init_addr_q[NODE_W-1:0];
    end

    always_comb begin
        case (INIT_MODE)
            0:       init_val = '0;
            1:       init_val = init_addr_val;
            default: init_val = '1;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_INIT;
            init_addr_q  <= '0;
            wr_err_q     <= 1'b0;
            rd_a_data_q  <= '0;
            rd_a_valid_q <= 1'b0;
            rd_b_data_q  <= '0;
            rd_b_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            init_addr_q  <= init_addr_d;
            wr_err_q     <= wr_err_d;
            rd_a_data_q  <= rd_a_data_d;
            rd_a_valid_q <= rd_a_valid_d;
            rd_b_data_q  <= rd_b_data_d;
            rd_b_valid_q <= rd_b_valid_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        init_addr_d = init_addr_q;
        if (clear) begin
            state_d     = S_INIT;
            init_addr_d = '0;
        end else if (state_q == S_INIT) begin
            if (init_addr_q == LAST) begin
                state_d     = S_READY;
                init_addr_d = '0;
            end else begin
                init_addr_d = init_addr_q + 1'b1;
            end
        end
    end

    // Output / datapath logic
    always_comb begin
        accept         = (state_q == S_READY) && !clear;
        wr_in_range    = {1'b0, wr_addr} < DEPTH_X;
        rd_a_in_range  = {1'b0, rd_a_addr} < DEPTH_X;
        rd_b_in_range  = {1'b0, rd_b_addr} < DEPTH_X;
        user_we        = accept && wr_en && wr_in_range && (wr_mask != '0);

        wr_merged = mem_q[wr_addr[IDX_W-1:0]];
        for (int unsigned i = 0; i < NF; i++) begin
            if (wr_mask[i]) begin
                wr_merged[i*FIELD_W +: FIELD_W] = wr_data[i*FIELD_W +: FIELD_W];
            end
        end

        mem_we    = 1'b0;
        mem_widx  = '0;
        mem_wdata = '0;
        if ((state_q == S_INIT) && !clear) begin
            mem_we    = 1'b1;
            mem_widx  = init_addr_q[IDX_W-1:0];
            mem_wdata = init_val;
        end else if (user_we) begin
            mem_we    = 1'b1;
            mem_widx  = wr_addr[IDX_W-1:0];
            mem_wdata = wr_merged;
        end

        wr_err_d = wr_err_q;
        if (clear) begin
            wr_err_d = 1'b0;
        end else if (accept && wr_en && !wr_in_range && (wr_mask != '0)) begin
            wr_err_d = 1'b1;
        end

        // Reads are write-first: a same-address write returns the merged word.
        rd_a_valid_d = accept && rd_a_en;
        rd_a_data_d  = rd_a_data_q;
        if (clear) begin
            rd_a_data_d = '0;
        end else if (rd_a_valid_d) begin
            if (!rd_a_in_range)
                rd_a_data_d = '0;
            else if (user_we && (wr_addr == rd_a_addr))
                rd_a_data_d = wr_merged;
            else
                rd_a_data_d = mem_q[rd_a_addr[IDX_W-1:0]];
        end

        rd_b_valid_d = accept && rd_b_en;
        rd_b_data_d  = rd_b_data_q;
        if (clear) begin
            rd_b_data_d = '0;
        end else if (rd_b_valid_d) begin
            if (!rd_b_in_range)
                rd_b_data_d = '0;
            else if (user_we && (wr_addr == rd_b_addr))
                rd_b_data_d = wr_merged;
            else
                rd_b_data_d = mem_q[rd_b_addr[IDX_W-1:0]];
        end
    end

    // Array storage has no reset; the init engine owns its contents.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_widx] <= mem_wdata;
        end
    end

    assign ready      = (state_q == S_READY);
    assign wr_err     = wr_err_q;
    assign rd_a_data  = rd_a_data_q;
    assign rd_a_valid = rd_a_valid_q;
    assign rd_b_data  = rd_b_data_q;
    assign rd_b_valid = rd_b_valid_q;

endmodule

// File: tb/tb_node_memory_mp.sv
module tb_node_memory_mp;

    localparam int NODE_W  = 12;
    localparam int DEPTH   = 32;
    localparam int ADDR_W  = 6;
    localparam int FIELD_W = 4;
    localparam int NF      = NODE_W / FIELD_W;

    logic              clk = 1'b0;
    logic              reset;
    logic              clear;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [NODE_W-1:0] wr_data;
    logic [NF-1:0]     wr_mask;
    logic              rd_a_en, rd_b_en;
    logic [ADDR_W-1:0] rd_a_addr, rd_b_addr;
    logic [NODE_W-1:0] rd_a_data, rd_b_data;
    logic              rd_a_valid, rd_b_valid;
    logic              ready, wr_err;

    int checks = 0;
    int errors = 0;

    // Reference model: plain array of node values plus the sticky error flag.
    int m_mem [DEPTH];
    bit m_err;
    int exp_a, exp_b;

    always #5 clk = ~clk;

    node_memory_mp #(
        .NODE_W(NODE_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W),
        .FIELD_W(FIELD_W), .INIT_MODE(1)
    ) dut (
        .clk(clk), .reset(reset), .clear(clear),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_mask(wr_mask),
        .rd_a_en(rd_a_en), .rd_a_addr(rd_a_addr), .rd_a_data(rd_a_data), .rd_a_valid(rd_a_valid),
        .rd_b_en(rd_b_en), .rd_b_addr(rd_b_addr), .rd_b_data(rd_b_data), .rd_b_valid(rd_b_valid),
        .ready(ready), .wr_err(wr_err)
    );

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        clear = 0; wr_en = 0; wr_addr = '0; wr_data = '0; wr_mask = '0;
        rd_a_en = 0; rd_a_addr = '0; rd_b_en = 0; rd_b_addr = '0;
    endtask

    task automatic model_init();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = i % 4096;
        m_err = 0;
    endtask

    // Apply one write to the model using field arithmetic.
    task automatic model_write(input int addr, input int data, input int mask);
        int old, res, fmask;
        if (mask == 0) return;
        if (addr >= DEPTH) begin
            m_err = 1;
            return;
        end
        old = m_mem[addr];
        res = 0;
        for (int f = 0; f < NF; f++) begin
            fmask = 15 << (4 * f);
            if ((mask >> f) & 1) res = res | (data & fmask);
            else                 res = res | (old & fmask);
        end
        m_mem[addr] = res;
    endtask

    function automatic int model_read(input int addr);
        return (addr < DEPTH) ? m_mem[addr] : 0;
    endfunction

    // After the edge that starts INIT: ready must be low for 31 edges, high after the 32nd.
    task automatic init_window(input string nm);
        for (int k = 1; k <= DEPTH; k++) begin
            cycle();
            checks++;
            if (ready !== (k == DEPTH)) begin
                errors++;
                $display("FAIL %s ready edge %0d: got %b want %b", nm, k, ready, (k == DEPTH));
            end
        end
    endtask

    task automatic test_reset();
        reset = 0;
        idle();
        repeat (2) cycle();
        checks += 5;
        if (ready !== 1'b0)      begin errors++; $display("FAIL reset_ready got %b want 0", ready); end
        if (wr_err !== 1'b0)     begin errors++; $display("FAIL reset_wr_err got %b want 0", wr_err); end
        if (rd_a_valid !== 1'b0 || rd_b_valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid got %b%b want 00", rd_a_valid, rd_b_valid);
        end
        if (rd_a_data !== 12'h000) begin errors++; $display("FAIL reset_a_data got %h want 000", rd_a_data); end
        if (rd_b_data !== 12'h000) begin errors++; $display("FAIL reset_b_data got %h want 000", rd_b_data); end
        @(negedge clk);
        reset = 1;
        model_init();
        init_window("reset_init");
        rd_a_en = 1; rd_a_addr = 7; rd_b_en = 1; rd_b_addr = 31;
        cycle();
        idle();
        checks += 2;
        if (rd_a_data !== 12'h007 || rd_a_valid !== 1'b1) begin
            errors++; $display("FAIL first_read_a got %h/%b want 007/1", rd_a_data, rd_a_valid);
        end
        if (rd_b_data !== 12'h01F || rd_b_valid !== 1'b1) begin
            errors++; $display("FAIL first_read_b got %h/%b want 01f/1", rd_b_data, rd_b_valid);
        end
        cycle();
        checks++;
        if (rd_a_valid !== 1'b0 || rd_a_data !== 12'h007) begin
            errors++; $display("FAIL read_hold_a got %h/%b want 007/0", rd_a_data, rd_a_valid);
        end
        exp_a = 12'h007; exp_b = 12'h01F;
    endtask

    task automatic test_mask_write();
        wr_en = 1; wr_addr = 5; wr_data = 12'hABC; wr_mask = 3'b101;
        model_write(5, 12'hABC, 3'b101);
        cycle();
        idle();
        rd_a_en = 1; rd_a_addr = 5;
        cycle();
        idle();
        checks++;
        if (rd_a_data !== 12'(model_read(5)) || rd_a_valid !== 1'b1) begin
            errors++; $display("FAIL mask_write got %h/%b want %h/1", rd_a_data, rd_a_valid, 12'(model_read(5)));
        end
    endtask

    task automatic test_bypass();
        wr_en = 1; wr_addr = 9; wr_data = 12'hFFF; wr_mask = 3'b010;
        rd_a_en = 1; rd_a_addr = 9; rd_b_en = 1; rd_b_addr = 9;
        model_write(9, 12'hFFF, 3'b010);
        cycle();
        idle();
        checks += 2;
        if (rd_a_data !== 12'(model_read(9)) || rd_a_valid !== 1'b1) begin
            errors++; $display("FAIL bypass_a got %h/%b want %h/1", rd_a_data, rd_a_valid, 12'(model_read(9)));
        end
        if (rd_b_data !== 12'(model_read(9)) || rd_b_valid !== 1'b1) begin
            errors++; $display("FAIL bypass_b got %h/%b want %h/1", rd_b_data, rd_b_valid, 12'(model_read(9)));
        end
    endtask

    task automatic test_out_of_range();
        wr_en = 1; wr_addr = 40; wr_data = 12'h123; wr_mask = 3'b111;
        model_write(40, 12'h123, 3'b111);
        cycle();
        idle();
        checks++;
        if (wr_err !== 1'b1) begin errors++; $display("FAIL oob_wr_err got %b want 1", wr_err); end
        for (int i = 0; i < DEPTH / 2; i++) begin
            rd_a_en = 1; rd_a_addr = 6'(2 * i); rd_b_en = 1; rd_b_addr = 6'(2 * i + 1);
            cycle();
            checks++;
            if (rd_a_data !== 12'(model_read(2 * i)) || rd_b_data !== 12'(model_read(2 * i + 1))) begin
                errors++;
                $display("FAIL oob_unchanged addr %0d got %h,%h want %h,%h", 2 * i, rd_a_data, rd_b_data,
                         12'(model_read(2 * i)), 12'(model_read(2 * i + 1)));
            end
        end
        rd_a_en = 1; rd_a_addr = 40; rd_b_en = 1; rd_b_addr = 63;
        cycle();
        idle();
        checks++;
        if (rd_a_data !== 12'h000 || rd_a_valid !== 1'b1 || rd_b_data !== 12'h000 || rd_b_valid !== 1'b1) begin
            errors++; $display("FAIL oob_read got %h/%b %h/%b want 000/1 000/1", rd_a_data, rd_a_valid, rd_b_data, rd_b_valid);
        end
        clear = 1;
        cycle();
        clear = 0;
        checks++;
        if (wr_err !== 1'b0 || ready !== 1'b0) begin
            errors++; $display("FAIL clear_flags got err %b ready %b want 0 0", wr_err, ready);
        end
        model_init();
        init_window("clear_init");
    endtask

    task automatic test_clear_drop();
        for (int i = 0; i < DEPTH; i++) begin
            wr_en = 1; wr_addr = 6'(i); wr_data = 12'h555; wr_mask = 3'b111;
            model_write(i, 12'h555, 3'b111);
            cycle();
        end
        idle();
        rd_a_en = 1; rd_a_addr = 3;
        cycle();
        idle();
        checks++;
        if (rd_a_data !== 12'h555) begin errors++; $display("FAIL fill_555 got %h want 555", rd_a_data); end
        clear = 1; wr_en = 1; wr_addr = 3; wr_data = 12'h0AA; wr_mask = 3'b111;
        rd_b_en = 1; rd_b_addr = 3;
        cycle();
        idle();
        checks++;
        if (rd_b_valid !== 1'b0) begin errors++; $display("FAIL clear_read_drop valid got %b want 0", rd_b_valid); end
        model_init();
        init_window("clear_drop_init");
        rd_a_en = 1; rd_a_addr = 3;
        cycle();
        idle();
        checks++;
        if (rd_a_data !== 12'(model_read(3)) || rd_a_valid !== 1'b1) begin
            errors++; $display("FAIL clear_write_drop got %h/%b want %h/1", rd_a_data, rd_a_valid, 12'(model_read(3)));
        end
        exp_a = model_read(3);
    endtask

    task automatic test_random();
        int wa, wd, wm, aa, ba;
        bit we, ae, be;
        for (int n = 0; n < 400; n++) begin
            we = ($urandom_range(0, 3) != 0);
            wa = ($urandom_range(0, 15) == 0) ? $urandom_range(DEPTH, 63) : $urandom_range(0, DEPTH - 1);
            wd = $urandom_range(0, 4095);
            wm = $urandom_range(0, 7);
            ae = (n == 0) || ($urandom_range(0, 2) != 0);
            be = (n == 0) || ($urandom_range(0, 2) != 0);
            aa = ($urandom_range(0, 9) == 0) ? $urandom_range(DEPTH, 63) : $urandom_range(0, DEPTH - 1);
            ba = ($urandom_range(0, 3) == 0) ? wa : $urandom_range(0, 63);
            wr_en = we; wr_addr = 6'(wa); wr_data = 12'(wd); wr_mask = 3'(wm);
            rd_a_en = ae; rd_a_addr = 6'(aa); rd_b_en = be; rd_b_addr = 6'(ba);
            if (we) model_write(wa, wd, wm);
            if (ae) exp_a = model_read(aa);
            if (be) exp_b = model_read(ba);
            cycle();
            checks++;
            if (rd_a_valid !== ae || rd_a_data !== 12'(exp_a) || rd_b_valid !== be ||
                rd_b_data !== 12'(exp_b) || wr_err !== m_err || ready !== 1'b1) begin
                errors++;
                $display("FAIL random cyc %0d got a %h/%b b %h/%b err %b rdy %b want a %h/%b b %h/%b err %b rdy 1",
                         n, rd_a_data, rd_a_valid, rd_b_data, rd_b_valid, wr_err, ready,
                         12'(exp_a), ae, 12'(exp_b), be, m_err);
            end
        end
        idle();
    endtask

    task automatic test_reset_abort();
        rd_a_en = 1; rd_a_addr = 20; rd_b_en = 1; rd_b_addr = 1;
        cycle();
        idle();
        #2 reset = 0;
        #1;
        checks++;
        if (ready !== 1'b0 || rd_a_valid !== 1'b0 || rd_b_valid !== 1'b0 ||
            rd_a_data !== 12'h000 || rd_b_data !== 12'h000 || wr_err !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_op got rdy %b v %b%b d %h %h err %b want all 0",
                     ready, rd_a_valid, rd_b_valid, rd_a_data, rd_b_data, wr_err);
        end
        @(negedge clk);
        reset = 1;
        repeat (10) cycle();
        #2 reset = 0;
        #1;
        checks++;
        if (ready !== 1'b0 || rd_a_valid !== 1'b0 || rd_a_data !== 12'h000) begin
            errors++; $display("FAIL async_reset_init got rdy %b v %b d %h want 0 0 000", ready, rd_a_valid, rd_a_data);
        end
        repeat (2) cycle();
        @(negedge clk);
        reset = 1;
        model_init();
        init_window("reset_restart");
        rd_a_en = 1; rd_a_addr = 10; rd_b_en = 1; rd_b_addr = 20;
        cycle();
        idle();
        checks++;
        if (rd_a_data !== 12'(model_read(10)) || rd_b_data !== 12'(model_read(20))) begin
            errors++; $display("FAIL restart_contents got %h %h want %h %h", rd_a_data, rd_b_data,
                               12'(model_read(10)), 12'(model_read(20)));
        end
    endtask

    initial begin
        test_reset();
        test_mask_write();
        test_bypass();
        test_out_of_range();
        test_clear_drop();
        test_random();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
